// File: rtl/router_slot_table.sv
// TDM slot table for a mesh router: per-input-port output selection indexed by a free-running
// slot counter, with node-addressed configuration writes, link enables and a sticky conflict flag.
module router_slot_table #(
  parameter int X         = 3,
  parameter int Y         = 3,
  parameter int NODE_ID   = 0,
  parameter int MAX_PORTS = 6,
  parameter int LUT_SIZE  = 8,
  localparam int NODES    = X * Y,
  localparam int SELW     = $clog2(MAX_PORTS + 1),
  localparam int PW       = $clog2(MAX_PORTS),
  localparam int SW       = $clog2(LUT_SIZE),
  localparam int NW       = $clog2(NODES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        slot_sync,
  input  logic [SELW-1:0]             lut_conf_data,
  input  logic [PW-1:0]               lut_conf_sel,
  input  logic [SW-1:0]               lut_conf_slot,
  input  logic [NW-1:0]               config_node,
  input  logic                        lut_conf_valid,
  input  logic                        link_en_valid,
  output logic [SW-1:0]               cur_slot,
  output logic [MAX_PORTS*SELW-1:0]   out_sel,
  output logic [MAX_PORTS-1:0]        out_valid,
  output logic [MAX_PORTS-1:0]        link_en,
  output logic                        conflict
);

  localparam logic [SELW-1:0] UNROUTED = SELW'(MAX_PORTS);

  logic [SELW-1:0] tbl   [MAX_PORTS][LUT_SIZE];
  logic [SELW-1:0] sel_q [MAX_PORTS];
  logic [SW-1:0]   slot_cnt;
  logic            node_hit;
  logic            tbl_we;
  logic            link_we;
  logic            dup;

  assign node_hit = (config_node == NW'(NODE_ID));

  // Out-of-range selectors, slots or port values are silently dropped.
  assign tbl_we  = lut_conf_valid && node_hit
                   && (32'(lut_conf_sel)  < 32'(MAX_PORTS))
                   && (32'(lut_conf_slot) < 32'(LUT_SIZE))
                   && (32'(lut_conf_data) <= 32'(MAX_PORTS));
  assign link_we = link_en_valid && node_hit
                   && (32'(lut_conf_sel) < 32'(MAX_PORTS));

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      cur_slot <= '0;
      link_en  <= '0;
      conflict <= 1'b0;
      for (int p = 0; p < MAX_PORTS; p++) begin
        sel_q[p] <= UNROUTED;
        for (int s = 0; s < LUT_SIZE; s++) begin
          tbl[p][s] <= UNROUTED;
        end
      end
    end else begin
      if (slot_sync || (slot_cnt == SW'(LUT_SIZE - 1))) begin
        slot_cnt <= '0;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // The lookup reads the pre-write contents, so a same-edge write shows up next period.
      cur_slot <= slot_cnt;
      for (int p = 0; p < MAX_PORTS; p++) begin
        sel_q[p] <= tbl[p][slot_cnt];
      end

      if (tbl_we) begin
        tbl[lut_conf_sel][lut_conf_slot] <= lut_conf_data;
      end
      if (link_we) begin
        link_en[lut_conf_sel] <= lut_conf_data[0];
      end

      if (dup) begin
        conflict <= 1'b1;
      end
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int a = 0; a < MAX_PORTS; a++) begin
      for (int b = a + 1; b < MAX_PORTS; b++) begin
        if ((sel_q[a] != UNROUTED) && (sel_q[a] == sel_q[b])) begin
          dup = 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < MAX_PORTS; p++) begin : g_port
    assign out_sel[p*SELW +: SELW] = sel_q[p];
    assign out_valid[p]            = (sel_q[p] != UNROUTED);
  end

endmodule

// File: tb/tb_router_slot_table.sv
// Directed bench for router_slot_table: a slot-table model scored every cycle plus literal spot checks.
module tb_router_slot_table;

  localparam int MP   = 6;
  localparam int LS   = 8;
  localparam int SELW = 3;
  localparam int PW   = 3;
  localparam int SW   = 3;
  localparam int NW   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              slot_sync = 1'b0;
  logic [SELW-1:0]   lut_conf_data = '0;
  logic [PW-1:0]     lut_conf_sel = '0;
  logic [SW-1:0]     lut_conf_slot = '0;
  logic [NW-1:0]     config_node = '0;
  logic              lut_conf_valid = 1'b0;
  logic              link_en_valid = 1'b0;
  logic [SW-1:0]     cur_slot;
  logic [MP*SELW-1:0] out_sel;
  logic [MP-1:0]     out_valid;
  logic [MP-1:0]     link_en;
  logic              conflict;

  router_slot_table dut (
    .clk(clk), .rst(rst), .slot_sync(slot_sync),
    .lut_conf_data(lut_conf_data), .lut_conf_sel(lut_conf_sel),
    .lut_conf_slot(lut_conf_slot), .config_node(config_node),
    .lut_conf_valid(lut_conf_valid), .link_en_valid(link_en_valid),
    .cur_slot(cur_slot), .out_sel(out_sel), .out_valid(out_valid),
    .link_en(link_en), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: table of port numbers, integer slot counter, routes looked up one edge late.
  int m_tbl [MP][LS];
  int m_sel [MP];
  int m_cnt, m_cur;
  bit [MP-1:0] m_link;
  bit m_conf;

  always @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < MP; p++) begin
        m_sel[p] = MP;
        for (int s = 0; s < LS; s++) m_tbl[p][s] = MP;
      end
      m_cnt = 0; m_cur = 0; m_link = '0; m_conf = 1'b0;
    end else begin
      for (int a = 0; a < MP; a++)
        for (int b = 0; b < MP; b++)
          if (a != b && m_sel[a] != MP && m_sel[a] == m_sel[b]) m_conf = 1'b1;
      m_cur = m_cnt;
      for (int p = 0; p < MP; p++) m_sel[p] = m_tbl[p][m_cnt];
      if (lut_conf_valid && int'(config_node) == 0 && int'(lut_conf_sel) < MP
          && int'(lut_conf_slot) < LS && int'(lut_conf_data) <= MP)
        m_tbl[lut_conf_sel][lut_conf_slot] = int'(lut_conf_data);
      if (link_en_valid && int'(config_node) == 0 && int'(lut_conf_sel) < MP)
        m_link[lut_conf_sel] = lut_conf_data[0];
      m_cnt = slot_sync ? 0 : (m_cnt + 1) % LS;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [MP*SELW-1:0] e_sel;
      logic [MP-1:0]      e_val;
      for (int p = 0; p < MP; p++) begin
        e_sel[p*SELW +: SELW] = SELW'(m_sel[p]);
        e_val[p] = (m_sel[p] != MP);
      end
      chk("m_cur_slot",  32'(cur_slot),  32'(m_cur));
      chk("m_out_sel",   32'(out_sel),   32'(e_sel));
      chk("m_out_valid", 32'(out_valid), 32'(e_val));
      chk("m_link_en",   32'(link_en),   32'(m_link));
      chk("m_conflict",  32'(conflict),  32'(m_conf));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_slot(input int t);
    bit hit = 1'b0;
    for (int i = 0; i < 3*LS && !hit; i++) begin
      @(negedge clk);
      if (int'(cur_slot) == t) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL wait_slot: cur_slot never reached %0d (last %0d)", t, cur_slot);
    end
  endtask

  task automatic tbl_write(input int node, input int sel, input int slot, input int data);
    config_node = NW'(node); lut_conf_sel = PW'(sel);
    lut_conf_slot = SW'(slot); lut_conf_data = SELW'(data);
    lut_conf_valid = 1'b1;
    cyc();
    lut_conf_valid = 1'b0;
  endtask

  task automatic link_write(input int node, input int sel, input int data);
    config_node = NW'(node); lut_conf_sel = PW'(sel); lut_conf_data = SELW'(data);
    link_en_valid = 1'b1;
    cyc();
    link_en_valid = 1'b0;
  endtask

  function automatic logic [SELW-1:0] sel_of(input int p);
    return out_sel[p*SELW +: SELW];
  endfunction

  initial begin
    @(posedge clk);
    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_cur_slot", 32'(cur_slot), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'(18'o666666));
    chk("rst_conflict", 32'(conflict), 32'd0);
    rst = 1'b0;

    // Idle two periods: slot sequence 0..7 twice, nothing routed.
    for (int i = 0; i < 2*LS; i++) begin
      cyc();
      chk("idle_slot", 32'(cur_slot), 32'(i % LS));
      chk("idle_valid", 32'(out_valid), 32'd0);
    end
    chk("idle_link", 32'(link_en), 32'd0);

    // Basic route, then a write addressed to another node.
    tbl_write(0, 2, 3, 4);
    wait_slot(3);
    chk("r20_sel2", 32'(sel_of(2)), 32'd4);
    chk("r20_valid", 32'(out_valid), 32'b000100);
    cyc();
    chk("r20_valid_next", 32'(out_valid), 32'd0);
    tbl_write(1, 2, 3, 5);
    wait_slot(3);
    chk("r20_other_node", 32'(sel_of(2)), 32'd4);

    // Write landing on the same edge as the lookup of that entry.
    wait_slot(4);
    tbl_write(0, 1, 5, 0);
    chk("r21_slot", 32'(cur_slot), 32'd5);
    chk("r21_old", 32'(sel_of(1)), 32'd6);
    wait_slot(5);
    chk("r21_new", 32'(sel_of(1)), 32'd0);
    chk("r21_valid", 32'(out_valid), 32'b000010);

    // Simultaneous link-enable and table writes share the selector.
    config_node = '0; lut_conf_sel = 3'd4; lut_conf_slot = 3'd0; lut_conf_data = 3'd1;
    lut_conf_valid = 1'b1; link_en_valid = 1'b1;
    cyc();
    lut_conf_valid = 1'b0; link_en_valid = 1'b0;
    chk("r22_link", 32'(link_en), 32'b010000);
    wait_slot(0);
    chk("r22_entry", 32'(sel_of(4)), 32'd1);
    link_write(1, 1, 1);
    chk("r22_link_other_node", 32'(link_en), 32'b010000);

    wait_slot(3);
    slot_sync = 1'b1;
    cyc();
    slot_sync = 1'b0;
    chk("r22_sync_first", 32'(cur_slot), 32'd4);
    cyc();
    chk("r22_sync_zero", 32'(cur_slot), 32'd0);
    cyc();
    chk("r22_sync_one", 32'(cur_slot), 32'd1);

    // Out-of-range writes are dropped; data==MAX_PORTS unroutes.
    tbl_write(0, 6, 1, 1);
    tbl_write(0, 7, 1, 2);
    tbl_write(0, 0, 1, 7);
    link_write(0, 6, 1);
    link_write(0, 7, 1);
    wait_slot(1);
    chk("r24_valid", 32'(out_valid), 32'd0);
    chk("r24_link", 32'(link_en), 32'b010000);
    tbl_write(0, 2, 1, 3);
    wait_slot(1);
    chk("r24_route", 32'(sel_of(2)), 32'd3);
    tbl_write(0, 2, 1, 6);
    wait_slot(1);
    chk("r24_unroute", 32'(out_valid), 32'd0);
    link_write(0, 4, 0);
    chk("r24_link_off", 32'(link_en), 32'd0);

    // Two ports onto the same output in slot 6.
    chk("r23_pre", 32'(conflict), 32'd0);
    tbl_write(0, 0, 6, 2);
    tbl_write(0, 3, 6, 2);
    wait_slot(6);
    chk("r23_at_slot", 32'(conflict), 32'd0);
    chk("r23_valid", 32'(out_valid), 32'b001001);
    cyc();
    chk("r23_set", 32'(conflict), 32'd1);
    repeat (LS + 3) cyc();
    chk("r23_held", 32'(conflict), 32'd1);

    // Reset pulse with a write on the same edge: write is lost.
    rst = 1'b1;
    config_node = '0; lut_conf_sel = 3'd5; lut_conf_slot = 3'd2; lut_conf_data = 3'd3;
    lut_conf_valid = 1'b1;
    cyc();
    rst = 1'b0; lut_conf_valid = 1'b0;
    chk("r23_rst_conf", 32'(conflict), 32'd0);
    cyc();
    chk("r23_rst_slot0", 32'(cur_slot), 32'd0);
    for (int i = 1; i < LS + 1; i++) begin
      cyc();
      chk("r23_cleared", 32'(out_valid), 32'd0);
    end
    chk("r23_conf_after", 32'(conflict), 32'd0);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
